alu_mdu: RTL and testbench
==========================

ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits (even, >= 8).
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 aluop  input  3  main-decoder op class: 000 add, 001 sub, 011 and, 100 or, 101 slt, others = decode funct.
REQ-006 funct  input  6  R-type function field.
REQ-007 valid  input  1  instruction present this cycle; qualifies mult/div start.
REQ-008 a  input  WIDTH  operand A (rs).
REQ-009 b  input  WIDTH  operand B (rt or extended immediate).
REQ-010 shamt  input  SHW  shift amount.
REQ-011 result  output  WIDTH  ALU / mfhi / mflo result.
REQ-012 zero  output  1  result == 0.
REQ-013 illegal  output  1  unrecognised funct under R-type decode.
REQ-014 busy  output  1  multiply/divide in progress.
REQ-015 done  output  1  one-cycle pulse when HI/LO written.
REQ-016 hi, lo  output  WIDTH each  architectural HI/LO registers.

Function
REQ-017 Single-cycle ops combinational, same cycle: add/addu 100000/100001, sub/subu 100010/100011, and 100100, or 100101, xor 100110, nor 100111, slt 101010 (signed), sltu 101011, sll 000000, srl 000010, sra 000011 (shift b by shamt), mfhi 010000, mflo 010010.
REQ-018 Arithmetic wraps modulo 2^WIDTH; no overflow trap; slt/sltu result = zero-extended 1-bit compare.
REQ-019 illegal=1 and result=0 for any funct not listed (incl. MDU funct, which drive result=0, illegal=0).
REQ-020 MDU ops: mult 011000, multu 011001, div 011010, divu 011011; start only when valid=1, R-type decode, state IDLE.
REQ-021 FSM states IDLE, MUL, DIV, FIN; IDLE->MUL/DIV on start, MUL/DIV->FIN after exactly WIDTH iteration cycles, FIN->IDLE unconditionally.
REQ-022 Start accepted at edge T: busy=1 during cycles T+1..T+WIDTH+1; during FIN, hi/lo written at the edge ending FIN, and done=1 and busy=0 in the cycle after (T+WIDTH+2).
REQ-023 Operands latched at start; later changes to a/b do not affect the operation.
REQ-024 Multiply: iterative shift-add on magnitudes; signed result negated when operand signs differ; {hi,lo} = 2*WIDTH-bit product.
REQ-025 Divide: restoring, one quotient bit per cycle; lo=quotient truncated toward zero, hi=remainder with sign of dividend.
REQ-026 Divide by zero: hi=a, lo=all ones, same latency, no flag.
REQ-027 MDU start while busy=1 is ignored (no queueing); hi/lo keep old values until done.
REQ-028 mfhi/mflo while busy return pre-operation hi/lo; stalling is the pipeline's responsibility via busy.
REQ-029 Single-cycle ops proceed normally while busy=1.

Reset
REQ-030 reset=1 at an edge: state=IDLE, counter=0, hi=0, lo=0, busy=0, done=0, in-flight op aborted without writing HI/LO.
REQ-031 reset has priority over a simultaneous start.

Verification (WIDTH=32)
REQ-032 aluop=010, funct=100000, a=5, b=7 -> result=12, zero=0, illegal=0.
REQ-033 aluop=001, a=b=0x00001234 -> result=0, zero=1; aluop=010, funct=000011, b=0x80000000, shamt=4 -> result=0xF8000000.
REQ-034 mult a=0xFFFFFFFD(-3), b=7 at edge T -> busy cycles T+1..T+33, done at T+34, hi=0xFFFFFFFF, lo=0xFFFFFFEB; second start at T+5 ignored.
REQ-035 div a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu a=10, b=0 -> hi=0x0000000A, lo=0xFFFFFFFF.
REQ-036 reset asserted at T+10 of a divide -> next cycle busy=0, hi=lo=0, done never pulses.
REQ-037 aluop=010, funct=111111 -> illegal=1, result=0, no MDU start.

Source files
------------

// File: rtl/alu_mdu.sv
// ALU with an iterative multiply/divide unit and architectural HI/LO registers.
// Single-cycle ops are combinational; mult/div take WIDTH iterations plus a finish cycle.
module alu_mdu #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       aluop,
   input  logic [5:0]       funct,
   input  logic             valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [SHW-1:0]   shamt,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             illegal,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {StIdle, StMul, StDiv, StFin} state_e;

   state_e state_q, state_d;

   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] hi_q, lo_q;
   logic             done_q;
   logic [WIDTH-1:0] acc_hi_q, acc_lo_q, opnd_q, dvd_q;
   logic             is_div_q, neg_q, rneg_q, dz_q;

   logic             rtype, mdu_funct, start, last_iter;
   logic             slt_s, slt_u;
   logic [WIDTH-1:0] alu_res;
   logic             alu_ill;

   assign rtype     = (aluop == 3'b010) || (aluop == 3'b110) || (aluop == 3'b111);
   assign mdu_funct = (funct[5:2] == 4'b0110);
   assign start     = valid && rtype && mdu_funct && (state_q == StIdle);
   assign last_iter = (cnt_q == CW'(WIDTH - 1));
   assign slt_s     = $signed(a) < $signed(b);
   assign slt_u     = a < b;

   always_comb begin
      alu_res = '0;
      alu_ill = 1'b0;
      case (aluop)
         3'b000:  alu_res = a + b;
         3'b001:  alu_res = a - b;
         3'b011:  alu_res = a & b;
         3'b100:  alu_res = a | b;
         3'b101:  alu_res = {{(WIDTH-1){1'b0}}, slt_s};
         default: begin
            case (funct)
               6'b100000, 6'b100001: alu_res = a + b;
               6'b100010, 6'b100011: alu_res = a - b;
               6'b100100: alu_res = a & b;
               6'b100101: alu_res = a | b;
               6'b100110: alu_res = a ^ b;
               6'b100111: alu_res = ~(a | b);
               6'b101010: alu_res = {{(WIDTH-1){1'b0}}, slt_s};
               6'b101011: alu_res = {{(WIDTH-1){1'b0}}, slt_u};
               6'b000000: alu_res = b << shamt;
               6'b000010: alu_res = b >> shamt;
               6'b000011: alu_res = $unsigned($signed(b) >>> shamt);
               6'b010000: alu_res = hi_q;
               6'b010010: alu_res = lo_q;
               6'b011000, 6'b011001, 6'b011010, 6'b011011: alu_res = '0;
               default:   alu_ill = 1'b1;
            endcase
         end
      endcase
   end

   assign result  = alu_res;
   assign zero    = (alu_res == '0);
   assign illegal = alu_ill;
   assign busy    = (state_q != StIdle);
   assign done    = done_q;
   assign hi      = hi_q;
   assign lo      = lo_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: if (start) state_d = funct[1] ? StDiv : StMul;
         StMul:  if (last_iter) state_d = StFin;
         StDiv:  if (last_iter) state_d = StFin;
         StFin:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= StIdle;
      else       state_q <= state_d;
   end

   // Operand magnitudes; funct[0]=1 selects the unsigned variants
   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;

   assign a_neg = ~funct[0] & a[WIDTH-1];
   assign b_neg = ~funct[0] & b[WIDTH-1];
   assign a_mag = a_neg ? -a : a;
   assign b_mag = b_neg ? -b : b;

   // Shift-add step: {carry, hi, lo} shifted right by one after the conditional add
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;

   assign mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
   assign mul_next = {mul_sum, acc_lo_q[WIDTH-1:1]};

   // Restoring step: acc_hi holds the partial remainder, acc_lo shifts dividend out/quotient in
   logic [WIDTH+1:0] div_diff;
   logic             div_ok;
   logic [WIDTH-1:0] div_rem_next, div_quo_next;

   assign div_diff     = {1'b0, acc_hi_q, acc_lo_q[WIDTH-1]} - {2'b00, opnd_q};
   assign div_ok       = ~div_diff[WIDTH+1];
   assign div_rem_next = div_ok ? div_diff[WIDTH-1:0] : {acc_hi_q[WIDTH-2:0], acc_lo_q[WIDTH-1]};
   assign div_quo_next = {acc_lo_q[WIDTH-2:0], div_ok};

   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   fin_hi, fin_lo;

   assign prod_fix = neg_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};

   always_comb begin
      fin_hi = prod_fix[2*WIDTH-1:WIDTH];
      fin_lo = prod_fix[WIDTH-1:0];
      if (is_div_q) begin
         if (dz_q) begin
            fin_hi = dvd_q;
            fin_lo = '1;
         end else begin
            fin_hi = rneg_q ? -acc_hi_q : acc_hi_q;
            fin_lo = neg_q ? -acc_lo_q : acc_lo_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         opnd_q   <= '0;
         dvd_q    <= '0;
         is_div_q <= 1'b0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         dz_q     <= 1'b0;
      end else begin
         done_q <= (state_q == StFin);
         if (start) begin
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= funct[1] ? a_mag : b_mag;
            opnd_q   <= funct[1] ? b_mag : a_mag;
            dvd_q    <= a;
            is_div_q <= funct[1];
            neg_q    <= a_neg ^ b_neg;
            rneg_q   <= a_neg;
            dz_q     <= (b == '0);
         end else if (state_q == StMul) begin
            {acc_hi_q, acc_lo_q} <= mul_next;
            cnt_q <= cnt_q + 1'b1;
         end else if (state_q == StDiv) begin
            acc_hi_q <= div_rem_next;
            acc_lo_q <= div_quo_next;
            cnt_q    <= cnt_q + 1'b1;
         end else if (state_q == StFin) begin
            hi_q <= fin_hi;
            lo_q <= fin_lo;
         end
      end
   end

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: vector table for single-cycle ops, scoreboard for MDU ops.
module tb_alu_mdu;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned SHW   = 5;

   logic             clk = 1'b0;
   logic             reset;
   logic [2:0]       aluop;
   logic [5:0]       funct;
   logic             valid;
   logic [WIDTH-1:0] a, b;
   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] result, hi, lo;
   logic             zero, illegal, busy, done;

   alu_mdu #(.WIDTH(WIDTH), .SHW(SHW)) dut (
      .clk(clk), .reset(reset), .aluop(aluop), .funct(funct), .valid(valid),
      .a(a), .b(b), .shamt(shamt), .result(result), .zero(zero), .illegal(illegal),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [63:0] sb_q[$];
   logic [31:0] exp_hi = '0, exp_lo = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] mdu_model(input logic [5:0] f, input logic [31:0] x,
                                             input logic [31:0] y);
      longint p;
      int q, r;
      logic [31:0] qv, rv;
      case (f[1:0])
         2'b00: begin
            p = longint'($signed(x)) * longint'($signed(y));
            return p;
         end
         2'b01: return {32'h0, x} * {32'h0, y};
         2'b10: begin
            if (y == 0) return {x, 32'hFFFF_FFFF};
            q = $signed(x) / $signed(y);
            r = $signed(x) % $signed(y);
            qv = q;
            rv = r;
            return {rv, qv};
         end
         default: begin
            if (y == 0) return {x, 32'hFFFF_FFFF};
            return {x % y, x / y};
         end
      endcase
   endfunction

   // Drive a start in the current cycle; the next posedge is edge T. Operands are scrambled after.
   task automatic start_op(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
      sb_q.push_back(mdu_model(f, x, y));
      valid = 1'b1; aluop = 3'b010; funct = f; a = x; b = y;
      @(posedge clk); #1;
      valid = 1'b0; a = $urandom; b = $urandom; funct = 6'b100000;
   endtask

   // Walk cycles T+first_c.. until done; optionally retry a start at cycle inject_c.
   task automatic wait_mdu(input int first_c, input int inject_c, output int busy_n,
                           output bit got_done);
      busy_n = 0;
      got_done = 1'b0;
      for (int c = first_c; c <= 100; c++) begin
         @(negedge clk);
         if (done) begin
            got_done = 1'b1;
            break;
         end
         if (busy) busy_n++;
         if (c == inject_c) begin
            valid = 1'b1; aluop = 3'b010; funct = 6'b011001; a = 32'd99; b = 32'd99;
         end else begin
            valid = 1'b0;
         end
      end
      valid = 1'b0;
   endtask

   task automatic finish_op(input string name);
      logic [63:0] e;
      chk({name, " busy at done"}, {63'h0, busy}, 64'h0);
      if (sb_q.size() == 0) begin
         chk({name, " scoreboard empty"}, 64'h1, 64'h0);
      end else begin
         e = sb_q.pop_front();
         chk({name, " hi"}, {32'h0, hi}, {32'h0, e[63:32]});
         chk({name, " lo"}, {32'h0, lo}, {32'h0, e[31:0]});
         exp_hi = e[63:32];
         exp_lo = e[31:0];
      end
   endtask

   typedef struct {
      logic [2:0]  op;
      logic [5:0]  fn;
      logic [31:0] va, vb;
      logic [4:0]  sh;
      logic [31:0] res;
      logic        z, ill;
   } vec_t;

   vec_t vecs[$];
   int   bn;
   bit   gd;
   logic [31:0] rx, ry;
   logic [5:0]  rf;
   bit   saw_done;

   initial begin
      reset = 1'b1; valid = 1'b0; aluop = '0; funct = '0; a = '0; b = '0; shamt = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("reset hi", {32'h0, hi}, 64'h0);
      chk("reset lo", {32'h0, lo}, 64'h0);
      chk("reset busy", {63'h0, busy}, 64'h0);
      chk("reset done", {63'h0, done}, 64'h0);

      vecs.push_back('{3'b010, 6'b100000, 32'd5, 32'd7, 5'd0, 32'd12, 1'b0, 1'b0});
      vecs.push_back('{3'b001, 6'b000000, 32'h1234, 32'h1234, 5'd0, 32'h0, 1'b1, 1'b0});
      vecs.push_back('{3'b010, 6'b000011, 32'h0, 32'h8000_0000, 5'd4, 32'hF800_0000, 1'b0, 1'b0});
      vecs.push_back('{3'b000, 6'b111111, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'h0, 1'b1, 1'b0});
      vecs.push_back('{3'b010, 6'b100010, 32'd3, 32'd5, 5'd0, 32'hFFFF_FFFE, 1'b0, 1'b0});
      vecs.push_back('{3'b011, 6'b000000, 32'hF0F0, 32'hFF00, 5'd0, 32'hF000, 1'b0, 1'b0});
      vecs.push_back('{3'b100, 6'b000000, 32'hF0F0, 32'h0F0F, 5'd0, 32'hFFFF, 1'b0, 1'b0});
      vecs.push_back('{3'b010, 6'b100110, 32'hFF, 32'h0F, 5'd0, 32'hF0, 1'b0, 1'b0});
      vecs.push_back('{3'b010, 6'b100111, 32'h0, 32'h0, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0});
      vecs.push_back('{3'b101, 6'b000000, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd1, 1'b0, 1'b0});
      vecs.push_back('{3'b010, 6'b101011, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0, 1'b1, 1'b0});
      vecs.push_back('{3'b010, 6'b000000, 32'h0, 32'd1, 5'd31, 32'h8000_0000, 1'b0, 1'b0});
      vecs.push_back('{3'b010, 6'b000010, 32'h0, 32'h8000_0000, 5'd4, 32'h0800_0000, 1'b0, 1'b0});
      vecs.push_back('{3'b010, 6'b111111, 32'd1, 32'd2, 5'd0, 32'h0, 1'b1, 1'b1});
      vecs.push_back('{3'b010, 6'b011000, 32'd3, 32'd4, 5'd0, 32'h0, 1'b1, 1'b0});
      vecs.push_back('{3'b110, 6'b100001, 32'h7FFF_FFFF, 32'd1, 5'd0, 32'h8000_0000, 1'b0, 1'b0});
      vecs.push_back('{3'b101, 6'b000000, 32'd1, 32'hFFFF_FFFF, 5'd0, 32'd0, 1'b1, 1'b0});
      vecs.push_back('{3'b111, 6'b101010, 32'h8000_0000, 32'h7FFF_FFFF, 5'd0, 32'd1, 1'b0, 1'b0});

      foreach (vecs[i]) begin
         aluop = vecs[i].op; funct = vecs[i].fn; a = vecs[i].va; b = vecs[i].vb;
         shamt = vecs[i].sh;
         @(negedge clk);
         chk($sformatf("vec%0d result", i), {32'h0, result}, {32'h0, vecs[i].res});
         chk($sformatf("vec%0d zero", i), {63'h0, zero}, {63'h0, vecs[i].z});
         chk($sformatf("vec%0d illegal", i), {63'h0, illegal}, {63'h0, vecs[i].ill});
      end
      shamt = '0;

      // mult -3*7 with a retried start at T+5 and operand scrambling
      start_op(6'b011000, 32'hFFFF_FFFD, 32'd7);
      wait_mdu(1, 4, bn, gd);
      chk("mult done seen", {63'h0, gd}, 64'h1);
      chk("mult busy cycles", 64'(bn), 64'(WIDTH + 1));
      finish_op("mult");
      @(negedge clk);
      chk("mult no queued start", {63'h0, busy}, 64'h0);
      chk("mult done one pulse", {63'h0, done}, 64'h0);

      // div -7/2, with reads of old HI/LO and a single-cycle op while busy
      start_op(6'b011010, 32'hFFFF_FFF9, 32'd2);
      aluop = 3'b010; funct = 6'b010000;
      @(negedge clk);
      chk("mfhi while busy", {32'h0, result}, {32'h0, exp_hi});
      funct = 6'b010010;
      @(negedge clk);
      chk("mflo while busy", {32'h0, result}, {32'h0, exp_lo});
      aluop = 3'b000; a = 32'd5; b = 32'd6;
      @(negedge clk);
      chk("add while busy", {32'h0, result}, 64'd11);
      chk("busy during div", {63'h0, busy}, 64'h1);
      wait_mdu(4, -1, bn, gd);
      chk("div done seen", {63'h0, gd}, 64'h1);
      finish_op("div");

      start_op(6'b011011, 32'd10, 32'd0);
      wait_mdu(1, -1, bn, gd);
      chk("divu0 busy cycles", 64'(bn), 64'(WIDTH + 1));
      finish_op("divu0");

      for (int k = 0; k < 6; k++) begin
         rf = {4'b0110, 2'(k % 4)};
         rx = (k == 0) ? 32'hFFFF_FFFF : $urandom;
         ry = (k == 0) ? 32'hFFFF_FFFF : ((k == 2) ? 32'hFFFF_FFF9 : $urandom);
         if (rf == 6'b011010 && rx == 32'h8000_0000 && ry == 32'hFFFF_FFFF) ry = 32'd3;
         if (k == 0) rf = 6'b011001;
         @(negedge clk);
         start_op(rf, rx, ry);
         wait_mdu(1, -1, bn, gd);
         chk($sformatf("rand%0d done seen", k), {63'h0, gd}, 64'h1);
         finish_op($sformatf("rand%0d", k));
      end

      // reset at T+10 of a divide aborts without writing HI/LO
      @(negedge clk);
      start_op(6'b011010, 32'd1000, 32'd7);
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      void'(sb_q.pop_back());
      exp_hi = '0; exp_lo = '0;
      @(negedge clk);
      chk("abort busy", {63'h0, busy}, 64'h0);
      chk("abort hi", {32'h0, hi}, 64'h0);
      chk("abort lo", {32'h0, lo}, 64'h0);
      saw_done = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done) saw_done = 1'b1;
      end
      chk("abort no done", {63'h0, saw_done}, 64'h0);

      // reset wins over a simultaneous start
      reset = 1'b1; valid = 1'b1; aluop = 3'b010; funct = 6'b011000; a = 32'd3; b = 32'd3;
      @(posedge clk); #1;
      reset = 1'b0; valid = 1'b0;
      @(negedge clk);
      chk("reset over start", {63'h0, busy}, 64'h0);

      // undefined funct with valid: flagged, no MDU start
      valid = 1'b1; aluop = 3'b010; funct = 6'b111111;
      @(negedge clk);
      chk("bad funct illegal", {63'h0, illegal}, 64'h1);
      chk("bad funct result", {32'h0, result}, 64'h0);
      @(posedge clk); #1;
      valid = 1'b0;
      @(negedge clk);
      chk("bad funct no start", {63'h0, busy}, 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
